// File: rtl/ab_seq_gen_if.sv
// ab_seq_gen_if: request/strobe bundle between a requester and ab_seq_gen.
//
// Handshake: there is no ready. valid_in is a one-cycle request sampled on
// posedge clk; the generator either accepts it (valid pulses one cycle
// later) or drops it (overflow/drop_cnt record the loss). a/b/valid are
// registered strobes for a downstream protocol checker.
//
// CNT_W must match the CNT_W of the ab_seq_gen instance it is bound to.
interface ab_seq_gen_if #(
    parameter int CNT_W = 8
) ();
    logic             valid_in;
    logic             valid;
    logic             a;
    logic             b;
    logic             busy;
    logic [3:0]       outstanding;
    logic             full;
    logic             overflow;
    logic [CNT_W-1:0] drop_cnt;

    // Requester side: raises valid_in, observes strobes and status.
    modport master (
        output valid_in,
        input  valid, a, b, busy, outstanding, full, overflow, drop_cnt
    );

    // Generator side (ab_seq_gen).
    modport slave (
        input  valid_in,
        output valid, a, b, busy, outstanding, full, overflow, drop_cnt
    );
endinterface

// File: rtl/ab_seq_gen.sv
// ab_seq_gen: launches one a/b strobe transaction per accepted request.
//
// Each accepted valid_in loads the lowest free slot with age=1. Ages advance
// every edge; a slot whose age reaches A_DLY drives a, one whose age reaches
// A_DLY+B_GAP drives b and is released on the following edge, where it may be
// reloaded by a new request. Strobes are computed from next-state ages and
// registered, so downstream logic sees glitch-free values.
//
// Optional build macro: AB_SEQ_HOLD_A_EN
//   defined   - a is held high from the a edge through the b edge (level).
//   undefined - a is a single-cycle pulse per transaction.
module ab_seq_gen #(
    parameter int A_DLY   = 1,
    parameter int B_GAP   = 3,
    parameter int MAX_OUT = 4,
    parameter int CNT_W   = 8
) (
    input logic          clk,
    input logic          rst,
    ab_seq_gen_if.slave  bus
);
    localparam int TOT   = A_DLY + B_GAP;
    localparam int AGE_W = $clog2(TOT + 1);

    localparam logic [AGE_W-1:0] AGE_ONE = AGE_W'(1);
    localparam logic [AGE_W-1:0] AGE_A   = AGE_W'(A_DLY);
    localparam logic [AGE_W-1:0] AGE_B   = AGE_W'(TOT);

    // Slot state
    logic [MAX_OUT-1:0]            r_act;
    logic [MAX_OUT-1:0][AGE_W-1:0] r_age;

    // Registered outputs
    logic             r_valid;
    logic             r_a;
    logic             r_b;
    logic [3:0]       r_cnt;
    logic             r_overflow;
    logic [CNT_W-1:0] r_drop_cnt;

    // Next-state
    logic [MAX_OUT-1:0]            w_act_nxt;
    logic [MAX_OUT-1:0][AGE_W-1:0] w_age_nxt;
    logic [MAX_OUT-1:0]            w_free;
    logic                          w_accept;
    logic                          w_drop;
    logic                          w_a_nxt;
    logic                          w_b_nxt;
    logic [3:0]                    w_cnt_nxt;

    // Slot aging/retire, lowest-free-slot allocation and strobe decode.
    always_comb begin
        w_act_nxt = r_act;
        w_age_nxt = r_age;
        w_free    = '0;
        w_accept  = 1'b0;
        w_drop    = 1'b0;
        w_a_nxt   = 1'b0;
        w_b_nxt   = 1'b0;
        w_cnt_nxt = 4'd0;

        // A slot at its final age retires at this edge, so it counts as free.
        for (int i = 0; i < MAX_OUT; i++) begin
            w_free[i] = !r_act[i] || (r_age[i] == AGE_B);
            if (r_act[i]) begin
                if (r_age[i] == AGE_B) begin
                    w_act_nxt[i] = 1'b0;
                    w_age_nxt[i] = '0;
                end else begin
                    w_age_nxt[i] = r_age[i] + AGE_ONE;
                end
            end
        end

        for (int i = 0; i < MAX_OUT; i++) begin
            if (bus.valid_in && !w_accept && w_free[i]) begin
                w_accept     = 1'b1;
                w_act_nxt[i] = 1'b1;
                w_age_nxt[i] = AGE_ONE;
            end
        end
        w_drop = bus.valid_in && !w_accept;

        // Strobes are ORed across slots; coinciding phases simply merge.
        for (int i = 0; i < MAX_OUT; i++) begin
            if (w_act_nxt[i]) begin
`ifdef AB_SEQ_HOLD_A_EN
                if (w_age_nxt[i] >= AGE_A) w_a_nxt = 1'b1;
`else
                if (w_age_nxt[i] == AGE_A) w_a_nxt = 1'b1;
`endif
                if (w_age_nxt[i] == AGE_B) w_b_nxt = 1'b1;
                w_cnt_nxt = w_cnt_nxt + 4'd1;
            end
        end
    end

    // Slot and output registers; reset aborts every in-flight transaction.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_act      <= '0;
            r_age      <= '0;
            r_valid    <= 1'b0;
            r_a        <= 1'b0;
            r_b        <= 1'b0;
            r_cnt      <= 4'd0;
            r_overflow <= 1'b0;
            r_drop_cnt <= '0;
        end else begin
            r_act   <= w_act_nxt;
            r_age   <= w_age_nxt;
            r_valid <= w_accept;
            r_a     <= w_a_nxt;
            r_b     <= w_b_nxt;
            r_cnt   <= w_cnt_nxt;
            if (w_drop) begin
                r_overflow <= 1'b1;
                if (r_drop_cnt != '1) r_drop_cnt <= r_drop_cnt + 1'b1;
            end
        end
    end

    assign bus.valid       = r_valid;
    assign bus.a           = r_a;
    assign bus.b           = r_b;
    assign bus.outstanding = r_cnt;
    assign bus.busy        = (r_cnt != 4'd0);
    assign bus.full        = (r_cnt == 4'(MAX_OUT));
    assign bus.overflow    = r_overflow;
    assign bus.drop_cnt    = r_drop_cnt;
endmodule

// File: tb/tb_ab_seq_gen.sv
// tb_ab_seq_gen: directed + random stimulus for two ab_seq_gen instances
// (default sizing, and MAX_OUT=2 with a 2-bit drop counter), checked against
// a model that keeps the list of accepted request edges and derives every
// output from the timing rules. Honors AB_SEQ_HOLD_A_EN like the design.
`timescale 1ns/1ps
module tb_ab_seq_gen;
    localparam int A_DLY = 1;
    localparam int B_GAP = 3;
    localparam int TOT   = A_DLY + B_GAP;
    localparam int MAX0  = 4;
    localparam int CNT0  = 8;
    localparam int MAX1  = 2;
    localparam int CNT1  = 2;

    // Clock/reset
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    ab_seq_gen_if #(.CNT_W(CNT0)) bus0 ();
    ab_seq_gen_if #(.CNT_W(CNT1)) bus1 ();

    ab_seq_gen #(.A_DLY(A_DLY), .B_GAP(B_GAP), .MAX_OUT(MAX0), .CNT_W(CNT0)) dut0 (
        .clk (clk),
        .rst (rst),
        .bus (bus0.slave)
    );

    ab_seq_gen #(.A_DLY(A_DLY), .B_GAP(B_GAP), .MAX_OUT(MAX1), .CNT_W(CNT1)) dut1 (
        .clk (clk),
        .rst (rst),
        .bus (bus1.slave)
    );

    // Model state: edges at which requests were accepted, and drop totals.
    int launch0[$];
    int launch1[$];
    int drops0;
    int drops1;
    int edge_n;
    int n_assert;
    int n_fail;

    // Transactions still holding a slot when edge e arrives (not retiring at e).
    function automatic int n_holding(input int q[$], input int e);
        int n = 0;
        foreach (q[k]) if (e < q[k] + TOT) n++;
        return n;
    endfunction

    // Transactions active during the cycle after edge e.
    function automatic int n_out(input int q[$], input int e);
        int n = 0;
        foreach (q[k]) if (q[k] <= e && e < q[k] + TOT) n++;
        return n;
    endfunction

    // a as sampled at edge e+1.
    function automatic logic exp_a(input int q[$], input int e);
        logic r = 1'b0;
        foreach (q[k]) begin
`ifdef AB_SEQ_HOLD_A_EN
            if (q[k] + A_DLY <= e + 1 && e + 1 <= q[k] + TOT) r = 1'b1;
`else
            if (q[k] + A_DLY == e + 1) r = 1'b1;
`endif
        end
        return r;
    endfunction

    // b as sampled at edge e+1.
    function automatic logic exp_b(input int q[$], input int e);
        logic r = 1'b0;
        foreach (q[k]) if (q[k] + TOT == e + 1) r = 1'b1;
        return r;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d (edge %0d)", tag, obs, exp, edge_n);
        end
    endtask

    task automatic check_dut(
        input string       nm,
        input int          q[$],
        input logic        acc,
        input int          drops,
        input int          max_out,
        input int          cnt_max,
        input logic [31:0] o_valid, o_a, o_b, o_busy, o_out, o_full, o_ovf, o_dcnt
    );
        int out;
        out = n_out(q, edge_n);
        chk({nm, ".valid"},       o_valid, 32'(acc));
        chk({nm, ".a"},           o_a,     32'(exp_a(q, edge_n)));
        chk({nm, ".b"},           o_b,     32'(exp_b(q, edge_n)));
        chk({nm, ".outstanding"}, o_out,   32'(out));
        chk({nm, ".busy"},        o_busy,  32'(out != 0));
        chk({nm, ".full"},        o_full,  32'(out == max_out));
        chk({nm, ".overflow"},    o_ovf,   32'(drops != 0));
        chk({nm, ".drop_cnt"},    o_dcnt,  32'((drops > cnt_max) ? cnt_max : drops));
    endtask

    // Everything must read zero while reset is applied.
    task automatic check_reset_vals();
        chk("rst.dut0.valid",       32'(bus0.valid),       32'd0);
        chk("rst.dut0.a",           32'(bus0.a),           32'd0);
        chk("rst.dut0.b",           32'(bus0.b),           32'd0);
        chk("rst.dut0.busy",        32'(bus0.busy),        32'd0);
        chk("rst.dut0.outstanding", 32'(bus0.outstanding), 32'd0);
        chk("rst.dut0.full",        32'(bus0.full),        32'd0);
        chk("rst.dut0.overflow",    32'(bus0.overflow),    32'd0);
        chk("rst.dut0.drop_cnt",    32'(bus0.drop_cnt),    32'd0);
        chk("rst.dut1.valid",       32'(bus1.valid),       32'd0);
        chk("rst.dut1.a",           32'(bus1.a),           32'd0);
        chk("rst.dut1.b",           32'(bus1.b),           32'd0);
        chk("rst.dut1.outstanding", 32'(bus1.outstanding), 32'd0);
        chk("rst.dut1.overflow",    32'(bus1.overflow),    32'd0);
        chk("rst.dut1.drop_cnt",    32'(bus1.drop_cnt),    32'd0);
    endtask

    // Driver: present requests for one edge, advance the model, then check.
    task automatic step(input logic v0, input logic v1);
        logic acc0;
        logic acc1;
        @(negedge clk);
        bus0.valid_in = v0;
        bus1.valid_in = v1;
        @(posedge clk);
        edge_n++;
        acc0 = v0 && (n_holding(launch0, edge_n) < MAX0);
        acc1 = v1 && (n_holding(launch1, edge_n) < MAX1);
        if (acc0) launch0.push_back(edge_n); else if (v0) drops0++;
        if (acc1) launch1.push_back(edge_n); else if (v1) drops1++;
        #1;
        check_dut("dut0", launch0, acc0, drops0, MAX0, (1 << CNT0) - 1,
                  32'(bus0.valid), 32'(bus0.a), 32'(bus0.b), 32'(bus0.busy),
                  32'(bus0.outstanding), 32'(bus0.full), 32'(bus0.overflow), 32'(bus0.drop_cnt));
        check_dut("dut1", launch1, acc1, drops1, MAX1, (1 << CNT1) - 1,
                  32'(bus1.valid), 32'(bus1.a), 32'(bus1.b), 32'(bus1.busy),
                  32'(bus1.outstanding), 32'(bus1.full), 32'(bus1.overflow), 32'(bus1.drop_cnt));
        while (launch0.size() > 0 && launch0[0] + TOT < edge_n) void'(launch0.pop_front());
        while (launch1.size() > 0 && launch1[0] + TOT < edge_n) void'(launch1.pop_front());
    endtask

    // Asynchronous assert between edges, release on a falling edge.
    task automatic do_reset();
        @(negedge clk);
        bus0.valid_in = 1'b0;
        bus1.valid_in = 1'b0;
        #2 rst = 1'b1;
        #1 check_reset_vals();
        @(posedge clk); edge_n++;
        @(posedge clk); edge_n++;
        #1 check_reset_vals();
        @(negedge clk);
        rst = 1'b0;
        launch0.delete();
        launch1.delete();
        drops0 = 0;
        drops1 = 0;
    endtask

    initial begin
        bus0.valid_in = 1'b0;
        bus1.valid_in = 1'b0;
        edge_n   = 0;
        n_assert = 0;
        n_fail   = 0;
        drops0   = 0;
        drops1   = 0;

        // Power-on reset
        do_reset();

        // Single request, then let it drain
        step(1'b1, 1'b1);
        repeat (6) step(1'b0, 1'b0);

        // Back-to-back: four requests, dut0 fills, dut1 drops two
        repeat (4) step(1'b1, 1'b1);
        repeat (6) step(1'b0, 1'b0);

        // Held request: retiring slot is reloaded at the same edge
        repeat (10) step(1'b1, 1'b0);
        repeat (6) step(1'b0, 1'b0);

        // Overflow pattern on dut1: accept, accept, drop, drop, accept, accept
        do_reset();
        repeat (6) step(1'b1, 1'b1);
        repeat (6) step(1'b0, 1'b0);

        // Reset mid-flight: nothing may surface after release
        do_reset();
        step(1'b1, 1'b1);
        step(1'b0, 1'b0);
        do_reset();
        repeat (8) step(1'b0, 1'b0);

        // Random requests (dut1 saturates its 2-bit drop counter)
        repeat (300) step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        do_reset();
        repeat (200) step(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)));
        repeat (6) step(1'b0, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
